// File: rtl/ppu_pkg.sv
// Shared PPU definitions: DMA and PPU phase enums, OAM geometry constants and
// the small helpers used by the OAM DMA controller and its port-A multiplexer.
package ppu_pkg;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_START,
    DMA_XFER
  } dma_state_t;

  // Position within one byte slot of a transfer.
  typedef enum logic [1:0] {
    SLOT_REQ,    // issue the source read
    SLOT_WAIT,   // waiting for src_valid
    SLOT_WRITE,  // captured byte goes to OAM this cycle
    SLOT_HOLD    // pad the slot out to its minimum length
  } dma_slot_t;

  typedef enum logic [1:0] {
    PHASE_HBLANK,
    PHASE_VBLANK,
    PHASE_OAM_SCAN,
    PHASE_DRAW
  } ppu_phase_t;

  localparam int unsigned OAM_BYTES        = 160;
  localparam logic [7:0]  ECHO_PAGE_BASE   = 8'hE0;
  localparam logic [7:0]  ECHO_PAGE_OFFSET = 8'h20;
  localparam logic [7:0]  OAM_ADDR_LIMIT   = 8'hA0;

  // PPU phases during which OAM belongs to the PPU.
  function automatic logic phase_uses_oam(ppu_phase_t phase);
    return (phase == PHASE_OAM_SCAN) || (phase == PHASE_DRAW);
  endfunction

  // Single definition of when the CPU loses OAM port A.
  function automatic logic oam_port_blocked(logic dma_active, logic ppu_oam_busy);
    return dma_active | ppu_oam_busy;
  endfunction

  // Pages E0..FF alias work RAM (echo region).
  function automatic logic [7:0] dma_src_page(logic [7:0] page);
    return (page >= ECHO_PAGE_BASE) ? 8'(page - ECHO_PAGE_OFFSET) : page;
  endfunction

endpackage

// File: rtl/oam_dma_ctrl_port_mux.sv
// oam_port_mux: combinational OAM port-A selection between the DMA engine and
// the CPU, with read masking while the CPU is blocked.
//  dma_active/dma_addr/dma_d/dma_we : DMA side (owns the port while active)
//  cpu_oam_addr/d_wr/cpu_oam_write  : CPU side; cpu_oam_q is its read data
//  ppu_oam_busy                     : PPU scan/draw in progress
//  oam_addr/oam_d/oam_we/oam_q      : OAM port A
module oam_port_mux
  import ppu_pkg::*;
(
  input  logic       dma_active,
  input  logic       ppu_oam_busy,
  input  logic [7:0] dma_addr,
  input  logic [7:0] dma_d,
  input  logic       dma_we,
  input  logic [7:0] cpu_oam_addr,
  input  logic [7:0] d_wr,
  input  logic       cpu_oam_write,
  output logic [7:0] cpu_oam_q,
  output logic [7:0] oam_addr,
  output logic [7:0] oam_d,
  output logic       oam_we,
  input  logic [7:0] oam_q
);

  logic blocked;
  logic cpu_in_range;

  always_comb begin
    blocked      = oam_port_blocked(dma_active, ppu_oam_busy);
    cpu_in_range = cpu_oam_addr < OAM_ADDR_LIMIT;

    if (dma_active) begin
      oam_addr = dma_addr;
      oam_d    = dma_d;
      oam_we   = dma_we;
    end else begin
      oam_addr = cpu_oam_addr;
      oam_d    = d_wr;
      oam_we   = cpu_oam_write & ~blocked & cpu_in_range;
    end

    if (blocked)
      cpu_oam_q = '1;
    else if (!cpu_in_range)
      cpu_oam_q = '0;
    else
      cpu_oam_q = oam_q;
  end

endmodule

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: OAM DMA engine plus OAM port-A arbiter.
// A write to the DMA register copies NUM_BYTES bytes from {page,8'h00} on the
// system bus into OAM 0..NUM_BYTES-1, one byte per CYCLES_PER_BYTE-cycle slot.
//  clk, rst (async, active-low)
//  dma_reg_write/d_wr/dma_reg_q     : DMA register write strobe, data, readback
//  cpu_oam_addr/cpu_oam_write/cpu_oam_q : CPU OAM access
//  ppu_oam_busy                     : PPU owns OAM (scan/draw)
//  oam_addr/oam_d/oam_we/oam_q      : OAM port A
//  src_addr/src_req/src_q/src_valid : system-bus read channel
//  dma_active                       : transfer in progress
module oam_dma_ctrl
  import ppu_pkg::*;
#(
  parameter int unsigned NUM_BYTES       = OAM_BYTES,
  parameter int unsigned CYCLES_PER_BYTE = 4,
  parameter int unsigned START_DELAY     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_reg_write,
  input  logic [7:0]  d_wr,
  output logic [7:0]  dma_reg_q,
  input  logic [7:0]  cpu_oam_addr,
  input  logic        cpu_oam_write,
  output logic [7:0]  cpu_oam_q,
  input  logic        ppu_oam_busy,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_d,
  output logic        oam_we,
  input  logic [7:0]  oam_q,
  output logic [15:0] src_addr,
  output logic        src_req,
  input  logic [7:0]  src_q,
  input  logic        src_valid,
  output logic        dma_active
);

  localparam int unsigned SLOT_W = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;
  localparam int unsigned DLY_W  = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CYCLES_PER_BYTE - 1);
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(START_DELAY - 1);
  localparam logic [7:0]        BYTE_LAST = 8'(NUM_BYTES - 1);

  dma_state_t        state_q, state_d;
  dma_slot_t         slot_q, slot_d;
  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d, slot_cnt_inc;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [7:0]        byte_q, byte_d;
  logic [7:0]        page_q, page_d;
  logic [7:0]        page_raw_q, page_raw_d;
  logic [7:0]        data_q, data_d;
  logic              slot_min_done;
  logic              dma_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DMA_IDLE;
      slot_q     <= SLOT_REQ;
      slot_cnt_q <= '0;
      dly_q      <= '0;
      byte_q     <= '0;
      page_q     <= '0;
      page_raw_q <= '1;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      slot_cnt_q <= slot_cnt_d;
      dly_q      <= dly_d;
      byte_q     <= byte_d;
      page_q     <= page_d;
      page_raw_q <= page_raw_d;
      data_q     <= data_d;
    end
  end

  // slot_cnt saturates at SLOT_LAST, so slot_min_done marks every cycle from
  // the last one of the nominal slot onward; a stalled slot ends right after
  // its write, a normal one at the nominal boundary.
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    slot_cnt_d    = slot_cnt_q;
    dly_d         = dly_q;
    byte_d        = byte_q;
    page_d        = page_q;
    page_raw_d    = page_raw_q;
    data_d        = data_q;
    slot_min_done = (slot_cnt_q == SLOT_LAST);
    slot_cnt_inc  = slot_min_done ? slot_cnt_q : slot_cnt_q + 1'b1;

    if (dma_reg_write) begin
      // Fresh start or restart: any in-flight slot is dropped.
      page_raw_d = d_wr;
      page_d     = dma_src_page(d_wr);
      state_d    = DMA_START;
      dly_d      = '0;
      slot_d     = SLOT_REQ;
      slot_cnt_d = '0;
      byte_d     = '0;
    end else begin
      unique case (state_q)
        DMA_IDLE: ;
        DMA_START: begin
          if (dly_q == DLY_LAST) begin
            state_d    = DMA_XFER;
            slot_d     = SLOT_REQ;
            slot_cnt_d = '0;
            byte_d     = '0;
          end else begin
            dly_d = dly_q + 1'b1;
          end
        end
        DMA_XFER: begin
          unique case (slot_q)
            SLOT_REQ: begin
              slot_d     = SLOT_WAIT;
              slot_cnt_d = slot_cnt_inc;
            end
            SLOT_WAIT: begin
              slot_cnt_d = slot_cnt_inc;
              if (src_valid) begin
                data_d = src_q;
                slot_d = SLOT_WRITE;
              end
            end
            SLOT_WRITE, SLOT_HOLD: begin
              if (slot_q == SLOT_WRITE && byte_q == BYTE_LAST) begin
                state_d    = DMA_IDLE;
                slot_d     = SLOT_REQ;
                slot_cnt_d = '0;
                byte_d     = '0;
              end else if (slot_min_done) begin
                slot_d     = SLOT_REQ;
                slot_cnt_d = '0;
                byte_d     = byte_q + 8'd1;
              end else begin
                slot_d     = SLOT_HOLD;
                slot_cnt_d = slot_cnt_inc;
              end
            end
            default: slot_d = SLOT_REQ;
          endcase
        end
        default: state_d = DMA_IDLE;
      endcase
    end
  end

  always_comb begin
    dma_active = (state_q != DMA_IDLE);
    src_req    = (state_q == DMA_XFER) && (slot_q == SLOT_REQ) && !dma_reg_write;
    dma_we     = (state_q == DMA_XFER) && (slot_q == SLOT_WRITE) && !dma_reg_write;
    src_addr   = {page_q, byte_q};
    dma_reg_q  = page_raw_q;
  end

  oam_port_mux u_port_mux (
    .dma_active   (dma_active),
    .ppu_oam_busy (ppu_oam_busy),
    .dma_addr     (byte_q),
    .dma_d        (data_q),
    .dma_we       (dma_we),
    .cpu_oam_addr (cpu_oam_addr),
    .d_wr         (d_wr),
    .cpu_oam_write(cpu_oam_write),
    .cpu_oam_q    (cpu_oam_q),
    .oam_addr     (oam_addr),
    .oam_d        (oam_d),
    .oam_we       (oam_we),
    .oam_q        (oam_q)
  );

endmodule

// File: tb/tb_oam_dma_ctrl.sv
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        dma_reg_write;
  logic [7:0]  d_wr;
  logic [7:0]  dma_reg_q;
  logic [7:0]  cpu_oam_addr;
  logic        cpu_oam_write;
  logic [7:0]  cpu_oam_q;
  logic        ppu_oam_busy;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_d;
  logic        oam_we;
  logic [7:0]  oam_q;
  logic [15:0] src_addr;
  logic        src_req;
  logic [7:0]  src_q;
  logic        src_valid;
  logic        dma_active;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  oam_dma_ctrl #(
    .NUM_BYTES      (160),
    .CYCLES_PER_BYTE(4),
    .START_DELAY    (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dma_reg_write(dma_reg_write),
    .d_wr         (d_wr),
    .dma_reg_q    (dma_reg_q),
    .cpu_oam_addr (cpu_oam_addr),
    .cpu_oam_write(cpu_oam_write),
    .cpu_oam_q    (cpu_oam_q),
    .ppu_oam_busy (ppu_oam_busy),
    .oam_addr     (oam_addr),
    .oam_d        (oam_d),
    .oam_we       (oam_we),
    .oam_q        (oam_q),
    .src_addr     (src_addr),
    .src_req      (src_req),
    .src_q        (src_q),
    .src_valid    (src_valid),
    .dma_active   (dma_active)
  );

  // Source memory contents: a fixed, page-dependent pattern.
  function automatic logic [7:0] src_byte(logic [15:0] a);
    return a[7:0] ^ 8'(a[15:8] + 8'h5B);
  endfunction

  // OAM model behind port A.
  logic [7:0] oam_mem [0:255];
  assign oam_q = oam_mem[oam_addr];

  // Activity logs filled by the monitor.
  logic [15:0] req_addr [$];
  int unsigned req_cyc  [$];
  logic [7:0]  wr_addr  [$];
  logic [7:0]  wr_data  [$];
  int unsigned wr_cyc   [$];
  logic        act_prev = 1'b0;
  int unsigned act_start = 0;
  int unsigned act_end   = 0;
  int unsigned act_falls = 0;

  always @(negedge clk) begin
    if (src_req) begin
      req_addr.push_back(src_addr);
      req_cyc.push_back(cyc);
    end
    if (oam_we) begin
      oam_mem[oam_addr] = oam_d;
      if (dma_active) begin
        wr_addr.push_back(oam_addr);
        wr_data.push_back(oam_d);
        wr_cyc.push_back(cyc);
      end
    end
    if (dma_active && !act_prev) act_start = cyc;
    if (!dma_active && act_prev) begin
      act_end = cyc;
      act_falls++;
    end
    act_prev = dma_active;
  end

  // Source bus responder: src_valid one cycle after src_req, or stall_lat
  // cycles after it for byte stall_byte when stalling is enabled.
  bit          stall_en   = 1'b0;
  logic [7:0]  stall_byte = 8'd0;
  int unsigned stall_lat  = 11;
  int unsigned pend       = 0;
  logic [15:0] pend_addr  = 16'h0;

  always @(negedge clk) begin
    src_valid = 1'b0;
    if (pend != 0) begin
      pend--;
      if (pend == 0) begin
        src_valid = 1'b1;
        src_q     = src_byte(pend_addr);
      end
    end
    if (src_req) begin
      pend_addr = src_addr;
      pend      = (stall_en && src_addr[7:0] == stall_byte) ? stall_lat : 1;
    end
  end

  task automatic clear_logs();
    req_addr.delete();
    req_cyc.delete();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    act_falls = 0;
  endtask

  task automatic do_dma_write(input logic [7:0] page, output int unsigned t);
    @(posedge clk); #1;
    d_wr          = page;
    dma_reg_write = 1'b1;
    t             = cyc;
    @(posedge clk); #1;
    dma_reg_write = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!dma_active) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_req_byte(input logic [7:0] b, input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk);
      if (src_req && src_addr[7:0] == b) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Checks one full clean transfer of 160 bytes from page `page` in the logs,
  // starting at log offsets req_base / wr_base.
  task automatic check_transfer(input string tag, input logic [7:0] page,
                                input int unsigned req_base, input int unsigned wr_base);
    for (int unsigned i = 0; i < 160; i++) begin
      checks++;
      if (req_base + i >= req_addr.size()) begin
        errors++;
        $display("FAIL %s req_missing[%0d]: got %0d reqs, need index %0d", tag, i,
                 req_addr.size(), req_base + i);
      end else if (req_addr[req_base + i] !== {page, 8'(i)}) begin
        errors++;
        $display("FAIL %s req_addr[%0d]: got %h expected %h", tag, i,
                 req_addr[req_base + i], {page, 8'(i)});
      end
      checks++;
      if (wr_base + i >= wr_addr.size()) begin
        errors++;
        $display("FAIL %s wr_missing[%0d]: got %0d writes", tag, i, wr_addr.size());
      end else if (wr_addr[wr_base + i] !== 8'(i) ||
                   wr_data[wr_base + i] !== src_byte({page, 8'(i)})) begin
        errors++;
        $display("FAIL %s oam_write[%0d]: got %h<=%h expected %h<=%h", tag, i,
                 wr_addr[wr_base + i], wr_data[wr_base + i], 8'(i), src_byte({page, 8'(i)}));
      end
    end
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    dma_reg_write = 1'b0;
    d_wr          = 8'h00;
    cpu_oam_addr  = 8'h00;
    cpu_oam_write = 1'b0;
    ppu_oam_busy  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (dma_active !== 1'b0) begin errors++; $display("FAIL reset_dma_active: got %b expected 0", dma_active); end
    checks++; if (src_req !== 1'b0) begin errors++; $display("FAIL reset_src_req: got %b expected 0", src_req); end
    checks++; if (oam_we !== 1'b0) begin errors++; $display("FAIL reset_oam_we: got %b expected 0", oam_we); end
    checks++; if (dma_reg_q !== 8'hFF) begin errors++; $display("FAIL reset_dma_reg_q: got %h expected FF", dma_reg_q); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (dma_active !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got %b expected 0", dma_active); end
  endtask

  task automatic test_basic_copy();
    int unsigned t;
    bit ok;
    clear_logs();
    stall_en = 1'b0;
    do_dma_write(8'hC1, t);
    wait_idle(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: dma_active still 1 after 2000 cycles"); end
    checks++; if (req_addr.size() !== 160) begin errors++; $display("FAIL basic_req_count: got %0d expected 160", req_addr.size()); end
    checks++; if (wr_addr.size() !== 160) begin errors++; $display("FAIL basic_wr_count: got %0d expected 160", wr_addr.size()); end
    check_transfer("basic", 8'hC1, 0, 0);
    checks++; if (act_start !== t + 1) begin errors++; $display("FAIL basic_active_start: got %0d expected %0d", act_start, t + 1); end
    // First request after the START_DELAY=4 START cycles.
    checks++; if (req_cyc.size() == 0 || req_cyc[0] !== t + 5) begin errors++; $display("FAIL basic_first_req_cycle: got %0d expected %0d", (req_cyc.size() != 0) ? req_cyc[0] : 0, t + 5); end
    // Active span: 4 START cycles + 159 full slots of 4 + final slot up to its
    // write at offset 2 (3 cycles) = 643.
    checks++; if (act_end - act_start !== 643) begin errors++; $display("FAIL basic_active_cycles: got %0d expected 643", act_end - act_start); end
    checks++; if (wr_cyc.size() != 160 || act_end !== wr_cyc[159] + 1) begin errors++; $display("FAIL basic_idle_after_last_write: got idle at %0d expected one after last write", act_end); end
    checks++; if (dma_reg_q !== 8'hC1) begin errors++; $display("FAIL basic_dma_reg_q: got %h expected C1", dma_reg_q); end
    checks++; if (oam_mem[8'h9F] !== src_byte(16'hC19F)) begin errors++; $display("FAIL basic_oam_last: got %h expected %h", oam_mem[8'h9F], src_byte(16'hC19F)); end
  endtask

  task automatic test_echo_remap();
    int unsigned t;
    bit ok;
    clear_logs();
    do_dma_write(8'hFE, t);
    checks++; if (dma_reg_q !== 8'hFE) begin errors++; $display("FAIL echo_dma_reg_q: got %h expected FE", dma_reg_q); end
    wait_idle(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL echo_timeout: dma_active still 1"); end
    checks++; if (req_addr.size() == 0 || req_addr[0] !== 16'hDE00) begin errors++; $display("FAIL echo_first_addr: got %h expected DE00", (req_addr.size() != 0) ? req_addr[0] : 16'h0); end
    check_transfer("echo", 8'hDE, 0, 0);
  endtask

  task automatic test_stall();
    int unsigned t;
    bit ok;
    clear_logs();
    stall_en   = 1'b1;
    stall_byte = 8'd5;
    do_dma_write(8'hC2, t);
    wait_idle(2000, ok);
    stall_en = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout: dma_active still 1"); end
    checks++; if (req_addr.size() !== 160) begin errors++; $display("FAIL stall_req_count: got %0d expected 160", req_addr.size()); end
    checks++; if (wr_addr.size() !== 160) begin errors++; $display("FAIL stall_wr_count: got %0d expected 160", wr_addr.size()); end
    check_transfer("stall", 8'hC2, 0, 0);
    if (req_cyc.size() > 6 && wr_cyc.size() > 5) begin
      // Valid 11 cycles after the request, write one cycle later.
      checks++; if (wr_cyc[5] - req_cyc[5] !== 12) begin errors++; $display("FAIL stall_write_delay: got %0d expected 12", wr_cyc[5] - req_cyc[5]); end
      checks++; if (req_cyc[6] !== wr_cyc[5] + 1) begin errors++; $display("FAIL stall_next_req: got cycle %0d expected %0d", req_cyc[6], wr_cyc[5] + 1); end
    end else begin
      checks++; errors++;
      $display("FAIL stall_logs_short: reqs %0d writes %0d", req_cyc.size(), wr_cyc.size());
    end
  endtask

  task automatic test_restart();
    int unsigned t0, t1;
    bit ok;
    clear_logs();
    do_dma_write(8'hC3, t0);
    wait_req_byte(8'd80, 1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL restart_wait_byte80: request for byte 80 never seen"); end
    do_dma_write(8'h80, t1);
    wait_idle(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL restart_timeout: dma_active still 1"); end
    checks++; if (act_falls !== 1) begin errors++; $display("FAIL restart_active_gaps: got %0d falls expected 1", act_falls); end
    checks++; if (wr_addr.size() !== 240) begin errors++; $display("FAIL restart_wr_count: got %0d expected 240", wr_addr.size()); end
    checks++; if (req_addr.size() !== 241) begin errors++; $display("FAIL restart_req_count: got %0d expected 241", req_addr.size()); end
    for (int unsigned i = 0; i < 80; i++) begin
      checks++;
      if (i >= wr_addr.size() || wr_addr[i] !== 8'(i) || wr_data[i] !== src_byte({8'hC3, 8'(i)})) begin
        errors++;
        $display("FAIL restart_first_part[%0d]: write log mismatch (size %0d)", i, wr_addr.size());
      end
    end
    checks++; if (req_cyc.size() < 82 || req_cyc[81] !== t1 + 5) begin errors++; $display("FAIL restart_first_req_cycle: got %0d expected %0d", (req_cyc.size() > 81) ? req_cyc[81] : 0, t1 + 5); end
    check_transfer("restart", 8'h80, 81, 80);
  endtask

  task automatic test_cpu_arb();
    int unsigned t;
    bit ok;
    logic [7:0] dma_val;
    dma_val = src_byte(16'hC410);
    clear_logs();
    do_dma_write(8'hC4, t);
    cpu_oam_addr  = 8'h10;
    d_wr          = 8'h77;
    cpu_oam_write = 1'b1;
    @(negedge clk);
    checks++; if (cpu_oam_q !== 8'hFF) begin errors++; $display("FAIL cpu_read_during_dma: got %h expected FF", cpu_oam_q); end
    checks++; if (oam_we !== 1'b0) begin errors++; $display("FAIL cpu_write_during_dma: oam_we got %b expected 0", oam_we); end
    @(posedge clk); #1;
    cpu_oam_write = 1'b0;
    wait_idle(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cpu_dma_timeout: dma_active still 1"); end
    checks++; if (oam_mem[8'h10] !== dma_val) begin errors++; $display("FAIL cpu_dma_oam10: got %h expected %h", oam_mem[8'h10], dma_val); end

    ppu_oam_busy  = 1'b1;
    d_wr          = 8'h55;
    cpu_oam_write = 1'b1;
    @(negedge clk);
    checks++; if (cpu_oam_q !== 8'hFF) begin errors++; $display("FAIL cpu_read_ppu_busy: got %h expected FF", cpu_oam_q); end
    checks++; if (oam_we !== 1'b0) begin errors++; $display("FAIL cpu_write_ppu_busy: oam_we got %b expected 0", oam_we); end
    @(posedge clk); #1;
    cpu_oam_write = 1'b0;
    ppu_oam_busy  = 1'b0;
    @(negedge clk);
    checks++; if (cpu_oam_q !== dma_val) begin errors++; $display("FAIL cpu_read_idle: got %h expected %h", cpu_oam_q, dma_val); end

    @(posedge clk); #1;
    d_wr          = 8'h5A;
    cpu_oam_write = 1'b1;
    @(negedge clk);
    checks++; if (oam_we !== 1'b1 || oam_addr !== 8'h10 || oam_d !== 8'h5A) begin errors++; $display("FAIL cpu_write_idle: got we=%b addr=%h d=%h expected 1/10/5A", oam_we, oam_addr, oam_d); end
    @(posedge clk); #1;
    cpu_oam_write = 1'b0;
    @(negedge clk);
    checks++; if (cpu_oam_q !== 8'h5A) begin errors++; $display("FAIL cpu_readback: got %h expected 5A", cpu_oam_q); end

    @(posedge clk); #1;
    cpu_oam_addr  = 8'hA5;
    d_wr          = 8'h66;
    cpu_oam_write = 1'b1;
    @(negedge clk);
    checks++; if (oam_we !== 1'b0) begin errors++; $display("FAIL cpu_write_out_of_range: oam_we got %b expected 0", oam_we); end
    checks++; if (cpu_oam_q !== 8'h00) begin errors++; $display("FAIL cpu_read_out_of_range: got %h expected 00", cpu_oam_q); end
    @(posedge clk); #1;
    cpu_oam_write = 1'b0;
    cpu_oam_addr  = 8'h00;
  endtask

  task automatic test_reset_mid_xfer();
    int unsigned t;
    bit ok;
    clear_logs();
    do_dma_write(8'hC5, t);
    wait_req_byte(8'd20, 1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_wait_byte20: request for byte 20 never seen"); end
    #1;
    rst = 1'b0;
    #1;
    checks++; if (dma_active !== 1'b0) begin errors++; $display("FAIL rstmid_dma_active: got %b expected 0", dma_active); end
    checks++; if (src_req !== 1'b0) begin errors++; $display("FAIL rstmid_src_req: got %b expected 0", src_req); end
    checks++; if (oam_we !== 1'b0) begin errors++; $display("FAIL rstmid_oam_we: got %b expected 0", oam_we); end
    checks++; if (dma_reg_q !== 8'hFF) begin errors++; $display("FAIL rstmid_dma_reg_q: got %h expected FF", dma_reg_q); end
    checks++; if (oam_mem[8'd19] !== src_byte(16'hC513)) begin errors++; $display("FAIL rstmid_partial_kept: got %h expected %h", oam_mem[8'd19], src_byte(16'hC513)); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (dma_active !== 1'b0) begin errors++; $display("FAIL rstmid_stays_idle: got %b expected 0", dma_active); end
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_echo_remap();
    test_stall();
    test_restart();
    test_cpu_arb();
    test_reset_mid_xfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
